hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//   Pipeline interlock unit: the stall side of the forwarding path. Detects load-use hazards
//   that forwarding cannot cover and freezes the pipe while data memory inserts wait states.
//   Drives PC/IF-ID/ID-EX/EX-MEM write enables and bubble flushes. Keeps stall statistics.
//   Sits beside the ID stage; sees ID sources, EX destination and the MEM-stage memory handshake.
// PARAMETERS
//   MAX_WAIT   16   memory wait cycles before Mem_Timeout is raised (1..255)
//   CNT_W      16   width of the saturating statistics counters
// PORTS
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous reset, active-high
//   ID_rs        in   5      ID-stage source register rs
//   ID_rt        in   5      ID-stage source register rt
//   ID_UsesRs    in   1      ID instruction reads rs
//   ID_UsesRt    in   1      ID instruction reads rt
//   ID_IsStore   in   1      ID instruction is a store (rt is store data)
//   EX_RegWrite  in   1      EX instruction writes a register
//   EX_Mem2R     in   1      EX instruction is a load
//   EX_WeSel     in   5      EX destination register
//   MEM_MemReq   in   1      MEM stage accessing data memory this cycle
//   Mem_Ready    in   1      data memory completes access this cycle
//   PC_Write     out  1      PC update enable
//   IFID_Write   out  1      IF/ID register enable
//   IDEX_Write   out  1      ID/EX register enable
//   IDEX_Flush   out  1      load bubble into ID/EX (controls zeroed)
//   EXMEM_Write  out  1      EX/MEM register enable
//   MEMWB_Flush  out  1      load bubble into MEM/WB
//   Mem_Timeout  out  1      sticky: wait exceeded MAX_WAIT
//   Load_Cnt     out  CNT_W  load-use bubbles inserted (saturating)
//   Wait_Cnt     out  CNT_W  memory wait cycles (saturating)
// BEHAVIOUR
//   - States: RUN, LDB (load bubble), MWAIT. Reset -> RUN, counters 0, Mem_Timeout 0, wait cnt 0.
//   - Enable/flush outputs are combinational from state+inputs. In reset: all *_Write=1, flushes=0.
//   - luse = EX_Mem2R & EX_RegWrite & EX_WeSel!=0 & ((ID_UsesRs & EX_WeSel==ID_rs) |
//     (ID_UsesRt & !ID_IsStore & EX_WeSel==ID_rt)). Store rt is not a hazard: MEM forwards it.
//   - mwait = MEM_MemReq & !Mem_Ready. mwait has priority over luse in every state.
//   - RUN/LDB, mwait: all *_Write=0, MEMWB_Flush=1, IDEX_Flush=0; next MWAIT.
//   - RUN, !mwait & luse: PC_Write=IFID_Write=0, IDEX_Flush=1, others 1; next LDB; Load_Cnt++.
//   - LDB, !mwait: all enables 1 (hazard cleared: load now in MEM); next RUN or LDB if luse again.
//   - MWAIT: mwait still 1 -> same freeze, stay, Wait_Cnt++ and wait cnt++.
//     Mem_Ready=1 -> release: all enables 1, no flush; next RUN; wait cnt cleared.
//     luse is not evaluated in MWAIT; it is re-evaluated on the first RUN cycle after.
//   - Wait_Cnt also increments on the RUN/LDB->MWAIT entry cycle.
//   - Wait cnt reaching MAX_WAIT sets Mem_Timeout; it stays 1 until rst. Stalling continues.
//   - Counters saturate at 2^CNT_W-1, never wrap.
//   - rst mid-wait or mid-bubble: immediate return to RUN, enables 1, counters cleared.
//   - Latency: stall decision 0 cycles (same cycle as hazard); one load-use bubble = 1 cycle.
// TESTING
//   1 EX lw $8 (Mem2R=1,WeSel=8), ID add uses rs=8 -> PC_Write=0,IFID_Write=0,IDEX_Flush=1 1 cyc; Load_Cnt=1.
//   2 EX lw $8, ID sw rt=8 (IsStore=1, UsesRs=0) -> no stall; EX lw $0 with rs=0 -> no stall.
//   3 MemReq=1, Mem_Ready low 3 cycles then high -> all enables 0 for 3 cycles, MEMWB_Flush=1, Wait_Cnt=3.
//   4 mwait and luse same cycle -> memory freeze wins, IDEX_Flush=0; bubble after release, Load_Cnt=1.
//   5 MAX_WAIT=4, Mem_Ready held 0 for 6 cyc -> Mem_Timeout=1 at 4th wait; stays 1 after Ready.
//   6 rst asserted asynchronously during MWAIT -> outputs enables 1 at once, Wait_Cnt=0, Mem_Timeout=0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Load-use and memory-wait interlock for the pipeline.
// Drives stage enables/flushes and keeps saturating stall statistics.
module hazard_stall_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_IsStore,
  input  logic             EX_RegWrite,
  input  logic             EX_Mem2R,
  input  logic [4:0]       EX_WeSel,
  input  logic             MEM_MemReq,
  input  logic             Mem_Ready,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IDEX_Write,
  output logic             IDEX_Flush,
  output logic             EXMEM_Write,
  output logic             MEMWB_Flush,
  output logic             Mem_Timeout,
  output logic [CNT_W-1:0] Load_Cnt,
  output logic [CNT_W-1:0] Wait_Cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LDB   = 2'd1,
    MWAIT = 2'd2
  } state_t;

  localparam logic [7:0] MW = 8'(MAX_WAIT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic             tmo_q, tmo_d;

  logic luse, mwait;
  logic pc_w, ifid_w, idex_w, exmem_w;
  logic idex_f, memwb_f;
  logic ld_inc, wt_inc;

  assign mwait = MEM_MemReq & ~Mem_Ready;

  // Store data on rt is forwarded in MEM, so it never interlocks.
  assign luse = EX_Mem2R & EX_RegWrite
              & (EX_WeSel != 5'd0)
              & ((ID_UsesRs & (EX_WeSel == ID_rs))
               | (ID_UsesRt & ~ID_IsStore
                  & (EX_WeSel == ID_rt)));

  always_comb begin
    state_d = state_q;
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    idex_w  = 1'b1;
    exmem_w = 1'b1;
    idex_f  = 1'b0;
    memwb_f = 1'b0;
    ld_inc  = 1'b0;
    wt_inc  = 1'b0;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      RUN, LDB: begin
        if (mwait) begin
          {pc_w, ifid_w, idex_w, exmem_w} = 4'b0000;
          memwb_f = 1'b1;
          wt_inc  = 1'b1;
          wcnt_d  = 8'd1;
          state_d = MWAIT;
        end else if (state_q == RUN && luse) begin
          pc_w    = 1'b0;
          ifid_w  = 1'b0;
          idex_f  = 1'b1;
          ld_inc  = 1'b1;
          state_d = LDB;
        end else begin
          state_d = luse ? LDB : RUN;
        end
      end
      MWAIT: begin
        if (mwait) begin
          {pc_w, ifid_w, idex_w, exmem_w} = 4'b0000;
          memwb_f = 1'b1;
          wt_inc  = 1'b1;
          if (wcnt_q != 8'hff)
            wcnt_d = wcnt_q + 8'd1;
        end else begin
          wcnt_d  = 8'd0;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    load_cnt_d = load_cnt_q;
    wait_cnt_d = wait_cnt_q;
    if (ld_inc && load_cnt_q != '1)
      load_cnt_d = load_cnt_q + CNT_W'(1);
    if (wt_inc && wait_cnt_q != '1)
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    tmo_d = tmo_q | (wcnt_d >= MW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      load_cnt_q <= '0;
      wait_cnt_q <= '0;
      wcnt_q     <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      wcnt_q     <= wcnt_d;
      tmo_q      <= tmo_d;
    end
  end

  // Reset forces a free-running pipe regardless of inputs.
  assign PC_Write    = pc_w | rst;
  assign IFID_Write  = ifid_w | rst;
  assign IDEX_Write  = idex_w | rst;
  assign EXMEM_Write = exmem_w | rst;
  assign IDEX_Flush  = idex_f & ~rst;
  assign MEMWB_Flush = memwb_f & ~rst;
  assign Mem_Timeout = tmo_q;
  assign Load_Cnt    = load_cnt_q;
  assign Wait_Cnt    = wait_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl.
// Small MAX_WAIT/CNT_W make timeout and saturation reachable.
module tb_hazard_stall_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    ID_rs, ID_rt, EX_WeSel;
  logic          ID_UsesRs, ID_UsesRt, ID_IsStore;
  logic          EX_RegWrite, EX_Mem2R;
  logic          MEM_MemReq, Mem_Ready;
  logic          PC_Write, IFID_Write, IDEX_Write;
  logic          IDEX_Flush, EXMEM_Write, MEMWB_Flush;
  logic          Mem_Timeout;
  logic [CW-1:0] Load_Cnt, Wait_Cnt;
  logic [5:0]    ctrl;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [5:0] IDLE   = 6'b111010;
  localparam logic [5:0] FREEZE = 6'b000001;
  localparam logic [5:0] BUBBLE = 6'b001110;

  hazard_stall_ctrl #(.MAX_WAIT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_IsStore(ID_IsStore),
    .EX_RegWrite(EX_RegWrite), .EX_Mem2R(EX_Mem2R),
    .EX_WeSel(EX_WeSel),
    .MEM_MemReq(MEM_MemReq), .Mem_Ready(Mem_Ready),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write),
    .IDEX_Write(IDEX_Write), .IDEX_Flush(IDEX_Flush),
    .EXMEM_Write(EXMEM_Write),
    .MEMWB_Flush(MEMWB_Flush),
    .Mem_Timeout(Mem_Timeout),
    .Load_Cnt(Load_Cnt), .Wait_Cnt(Wait_Cnt)
  );

  always #5 clk = ~clk;

  assign ctrl = {PC_Write, IFID_Write, IDEX_Write,
                 IDEX_Flush, EXMEM_Write, MEMWB_Flush};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ID_rs = 5'd0; ID_rt = 5'd0; EX_WeSel = 5'd0;
    ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
    ID_IsStore = 1'b0; EX_RegWrite = 1'b0;
    EX_Mem2R = 1'b0; MEM_MemReq = 1'b0;
    Mem_Ready = 1'b0;
  endtask

  task automatic ld(input logic [4:0] rd);
    EX_Mem2R = 1'b1; EX_RegWrite = 1'b1;
    EX_WeSel = rd;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    MEM_MemReq = 1'b1;
    #2;
    chk("rst_ctrl", 32'(ctrl), 32'(IDLE));
    chk("rst_ld", 32'(Load_Cnt), 0);
    chk("rst_wt", 32'(Wait_Cnt), 0);
    chk("rst_tmo", 32'(Mem_Timeout), 0);
    cyc(); cyc();
    rst = 1'b0;
    idle();
    #1;
    chk("run_idle", 32'(ctrl), 32'(IDLE));

    // load-use on rs
    ld(5'd8); ID_rs = 5'd8; ID_UsesRs = 1'b1;
    #1;
    chk("luse_rs", 32'(ctrl), 32'(BUBBLE));
    cyc();
    chk("ldcnt1", 32'(Load_Cnt), 1);
    idle(); ID_rs = 5'd8; ID_UsesRs = 1'b1;
    #1;
    chk("ldb_rel", 32'(ctrl), 32'(IDLE));
    cyc();

    // load-use on rt
    idle(); ld(5'd9);
    ID_rt = 5'd9; ID_UsesRt = 1'b1;
    #1;
    chk("luse_rt", 32'(ctrl), 32'(BUBBLE));
    cyc();
    chk("ldcnt2", 32'(Load_Cnt), 2);
    idle();
    cyc();

    // non-hazards
    ld(5'd8); ID_rt = 5'd8; ID_UsesRt = 1'b1;
    ID_IsStore = 1'b1;
    #1;
    chk("store_rt", 32'(ctrl), 32'(IDLE));
    cyc();
    idle(); ld(5'd0); ID_UsesRs = 1'b1;
    #1;
    chk("r0_dest", 32'(ctrl), 32'(IDLE));
    cyc();
    idle(); EX_RegWrite = 1'b1; EX_WeSel = 5'd8;
    ID_rs = 5'd8; ID_UsesRs = 1'b1;
    #1;
    chk("alu_dest", 32'(ctrl), 32'(IDLE));
    cyc();
    chk("ldcnt_keep", 32'(Load_Cnt), 2);

    // three wait cycles then ready
    idle(); MEM_MemReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mwait3", 32'(ctrl), 32'(FREEZE));
      cyc();
    end
    Mem_Ready = 1'b1;
    #1;
    chk("mrel", 32'(ctrl), 32'(IDLE));
    cyc();
    chk("wtcnt3", 32'(Wait_Cnt), 3);
    chk("no_tmo", 32'(Mem_Timeout), 0);

    // wait and load-use together
    idle(); MEM_MemReq = 1'b1;
    ld(5'd5); ID_rs = 5'd5; ID_UsesRs = 1'b1;
    #1;
    chk("mw_prio", 32'(ctrl), 32'(FREEZE));
    cyc();
    chk("wtcnt4", 32'(Wait_Cnt), 4);
    Mem_Ready = 1'b1;
    #1;
    chk("mw_rel_luse", 32'(ctrl), 32'(IDLE));
    cyc();
    MEM_MemReq = 1'b0; Mem_Ready = 1'b0;
    #1;
    chk("post_bub", 32'(ctrl), 32'(BUBBLE));
    cyc();
    chk("ldcnt3", 32'(Load_Cnt), 3);
    idle();
    cyc();

    // timeout after the fourth wait cycle
    MEM_MemReq = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      #1;
      chk("to_frz", 32'(ctrl), 32'(FREEZE));
      cyc();
      chk("tmo_seq", 32'(Mem_Timeout),
          (i >= 4) ? 32'd1 : 32'd0);
    end
    chk("wtcnt10", 32'(Wait_Cnt), 10);
    Mem_Ready = 1'b1;
    cyc();
    chk("tmo_stky", 32'(Mem_Timeout), 1);

    // saturate Wait_Cnt
    Mem_Ready = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    chk("wt_sat", 32'(Wait_Cnt), 15);
    #1;
    chk("sat_frz", 32'(ctrl), 32'(FREEZE));

    // asynchronous reset mid-wait
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ctrl", 32'(ctrl), 32'(IDLE));
    chk("arst_wt", 32'(Wait_Cnt), 0);
    chk("arst_ld", 32'(Load_Cnt), 0);
    chk("arst_tmo", 32'(Mem_Timeout), 0);
    cyc();
    rst = 1'b0;
    idle();
    #1;
    chk("post_rst", 32'(ctrl), 32'(IDLE));
    MEM_MemReq = 1'b1;
    #1;
    chk("reentry", 32'(ctrl), 32'(FREEZE));
    cyc();
    chk("wtcnt_new", 32'(Wait_Cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
